// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, next-PC select (seq/branch/JAL/JALR) and the IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misalign flag and blocks misaligned PC loads.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        decision_in,
  input  logic              if_id_flush,
  input  logic              pc_le,
  input  logic              if_id_le,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jal_target,
  input  logic [ADDR_W-1:0] jalr_target,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              misalign,
`endif
  output logic              if_id_valid
);

  localparam int unsigned INSTR_W = 32;
  localparam logic [2:0]  DEC_BRANCH = 3'b001;
  localparam logic [2:0]  DEC_JAL    = 3'b010;
  localparam logic [2:0]  DEC_JALR   = 3'b011;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0]  target;
  logic               redirect;
  logic               pc_load;
  logic               bubble;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               misalign_q, misalign_d;
  logic               misalign_hit;
`endif

  // Next-PC select; reserved decisions fall back to sequential
  always_comb begin
    redirect = 1'b0;
    target   = pc_q + ADDR_W'(4);
    case (decision_in)
      DEC_BRANCH: begin redirect = 1'b1; target = branch_target; end
      DEC_JAL:    begin redirect = 1'b1; target = jal_target; end
      DEC_JALR:   begin redirect = 1'b1; target = jalr_target & ~ADDR_W'(1); end
      default:    ;
    endcase
  end

  // PC and IF/ID next state; a redirect overrides a PC stall
  always_comb begin
    pc_load       = redirect | pc_le;
    pc_d          = pc_load ? target : pc_q;
    bubble        = if_id_flush;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_hit  = pc_load && (target[1:0] != 2'b00);
    misalign_d    = misalign_q | misalign_hit;
    if (misalign_hit) begin
      pc_d   = pc_q;
      bubble = 1'b1;
    end
`endif
    if (bubble) begin
      if_id_instr_d = NOP_INSTR;
      if_id_pc_d    = '0;
      if_id_valid_d = 1'b0;
    end else if (if_id_le) begin
      if_id_instr_d = imem_rdata;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a driver pushes the model's expected post-edge state,
// a monitor pops and compares one entry per clock. Honours FETCH_ALIGN_CHECK_EN if defined.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  decision_in = 3'b000;
  logic        if_id_flush = 1'b0;
  logic        pc_le = 1'b0;
  logic        if_id_le = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] jal_target = '0;
  logic [31:0] jalr_target = '0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        misalign;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .decision_in(decision_in), .if_id_flush(if_id_flush),
    .pc_le(pc_le), .if_id_le(if_id_le), .branch_target(branch_target),
    .jal_target(jal_target), .jalr_target(jalr_target), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .if_id_valid(if_id_valid)
  );

`ifndef FETCH_ALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed hash of the address
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_fn(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic        mis;
    bit          dpc_en;
    logic [31:0] dpc;
    bit          dv_en;
    logic        dv;
    bit          dmis_en;
    logic        dmis;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_pc = '0, m_instr = NOP, m_ipc = '0;
  logic        m_valid = 1'b0, m_mis = 1'b0;
  bit          stim_done = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic step(input bit rst, input logic [2:0] dec, input bit fl, input bit ple,
                      input bit ile, input logic [31:0] bt, input logic [31:0] jt,
                      input logic [31:0] jrt,
                      input bit dpc_en = 0, input logic [31:0] dpc = 0,
                      input bit dv_en = 0, input bit dv = 0,
                      input bit dmis_en = 0, input bit dmis = 0);
    exp_t        e;
    logic [31:0] tgt;
    bit          redir, load, mis_hit;
    @(negedge clk);
    reset = rst; decision_in = dec; if_id_flush = fl; pc_le = ple; if_id_le = ile;
    branch_target = bt; jal_target = jt; jalr_target = jrt;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else begin
      redir = 1'b1;
      case (dec)
        3'd1: tgt = bt;
        3'd2: tgt = jt;
        3'd3: tgt = jrt - (jrt % 2);
        default: begin redir = 1'b0; tgt = m_pc + 32'd4; end
      endcase
      load = redir || ple;
      mis_hit = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_hit = load && (tgt % 4 != 0);
`endif
      if (fl || mis_hit) begin
        m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
      end else if (ile) begin
        m_instr = mem_fn(m_pc); m_ipc = m_pc; m_valid = 1'b1;
      end
      if (mis_hit) m_mis = 1'b1;
      else if (load) m_pc = tgt;
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.valid = m_valid; e.mis = m_mis;
    e.dpc_en = dpc_en; e.dpc = dpc; e.dv_en = dv_en; e.dv = dv;
    e.dmis_en = dmis_en; e.dmis = dmis;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 7) != 0) t = t & 32'hFFFF_FFFC;
    return t;
  endfunction

  // Driver: directed scenarios, then randomized traffic
  initial begin
    step(1, 0, 0, 1, 1, 0, 0, 0, 1, 32'h0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 1, 32'h0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h4, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h8);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'hC);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h10);
    step(0, 3'b001, 0, 1, 1, 32'h40, 0, 0, 1, 32'h40, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h44);
    step(0, 3'b010, 1, 1, 1, 0, 32'h100, 0, 1, 32'h100, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h104, 1, 1);
    step(0, 3'b011, 0, 0, 1, 0, 0, 32'h205, 1, 32'h204);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204);
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h204, 1, 0);
    step(0, 3'b110, 0, 1, 1, 32'h80, 32'h80, 32'h80, 1, 32'h208);
    step(0, 3'b001, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h0, 1, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    step(0, 3'b001, 0, 1, 1, 32'h42, 0, 0, 1, 32'h0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h4, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1, 0, 0, 0, 1, 32'h0, 1, 0, 1, 0);
`endif
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] dec;
      dec = ($urandom_range(0, 9) < 5) ? 3'b000 : 3'($urandom_range(1, 7));
      step($urandom_range(0, 63) == 0, dec, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
           rnd_tgt(), rnd_tgt(), $urandom);
    end
    stim_done = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge
  initial begin
    exp_t e;
    int   idle = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        idle = 0;
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc", if_id_pc, e.ipc);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign", 32'(misalign), 32'(e.mis));
`endif
        if (e.dpc_en) chk("pc_directed", pc, e.dpc);
        if (e.dv_en) begin
          chk("valid_directed", 32'(if_id_valid), 32'(e.dv));
          if (!e.dv) chk("bubble_instr", if_id_instr, NOP);
        end
        if (e.dmis_en) chk("misalign_directed", 32'(misalign), 32'(e.dmis));
      end else if (stim_done) begin
        break;
      end else begin
        idle++;
        if (idle > 20) begin
          n_tests++;
          n_fail++;
          $display("FAIL watchdog actual=idle%0d required=traffic", idle);
          break;
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
